// File: rtl/z88_vga.sv
// z88_vga: 640x480 VGA timing plus upscaled Z88 LCD window fetched from VRAM.
// Optional VGA_SCANLINE_EN halves the colour on odd VGA lines inside the window.
module z88_vga (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_ena,
  input  logic [2:0]  vram_data,
  output logic [14:0] vram_addr,
  output logic        new_fr_tgl,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_de,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  logic [9:0]  h_q, h_d, v_q, v_d, hd_q, hd_d, vd_q, vd_d;
  logic        vld_q, vld_d, tgl_q, tgl_d, hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic [2:0]  dat_q, dat_d, px;
  logic [11:0] rgb_q, rgb_d, base, col;
  logic        win, bit_on;
  assign vram_addr  = {h_q[9:1], 6'((v_q - 10'd112) >> 2) + 6'd16};
  assign new_fr_tgl = tgl_q;
  assign vga_hs     = hs_q;
  assign vga_vs     = vs_q;
  assign vga_de     = de_q;
  assign {vga_r, vga_g, vga_b} = rgb_q;
  always_comb begin
    win    = vld_q && hd_q < 10'd640 && vd_q >= 10'd112 && vd_q <= 10'd367;
    px     = hd_q[0] ? dat_q : vram_data;
    bit_on = hd_q[0] ? px[0] : px[1];
    base   = bit_on ? (px[2] ? 12'h666 : 12'h222) : 12'hAC8;
`ifdef VGA_SCANLINE_EN
    col    = vd_q[0] ? {1'b0, base[11:9], 1'b0, base[7:5], 1'b0, base[3:1]} : base;
`else
    col    = base;
`endif
    h_d    = h_q;
    v_d    = v_q;
    hd_d   = hd_q;
    vd_d   = vd_q;
    vld_d  = vld_q;
    dat_d  = dat_q;
    tgl_d  = tgl_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    de_d   = de_q;
    rgb_d  = rgb_q;
    if (pix_ena) begin
      h_d   = h_q == 10'd799 ? 10'd0 : h_q + 10'd1;
      v_d   = h_q != 10'd799 ? v_q : (v_q == 10'd524 ? 10'd0 : v_q + 10'd1);
      hd_d  = h_q;
      vd_d  = v_q;
      vld_d = 1'b1;
      dat_d = h_q[0] ? vram_data : dat_q;
      tgl_d = tgl_q ^ (h_q == 10'd0 && v_q == 10'd480);
      hs_d  = !(hd_q >= 10'd656 && hd_q <= 10'd751);
      vs_d  = !(vd_q == 10'd490 || vd_q == 10'd491);
      de_d  = vld_q && hd_q < 10'd640 && vd_q < 10'd480;
      rgb_d = win ? col : 12'h000;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q   <= '0;
      v_q   <= '0;
      hd_q  <= '0;
      vd_q  <= '0;
      vld_q <= 1'b0;
      dat_q <= '0;
      tgl_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      hd_q  <= hd_d;
      vd_q  <= vd_d;
      vld_q <= vld_d;
      dat_q <= dat_d;
      tgl_q <= tgl_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      rgb_q <= rgb_d;
    end
  end
endmodule

// File: tb/tb_z88_vga.sv
// tb_z88_vga: reference-model bench for z88_vga (VGA_SCANLINE_EN honoured if defined).
module tb_z88_vga;
  logic clk = 0, rst = 1, pix_ena = 0;
  logic [2:0] vram_data = 0;
  logic [14:0] vram_addr;
  logic new_fr_tgl, vga_hs, vga_vs, vga_de;
  logic [3:0] vga_r, vga_g, vga_b;
  logic [2:0] mem [0:32767];
  int n = 0, nvec = 0, nerr = 0;
  bit stat_on = 0;
  int de_cnt = 0, hs_fall = 0, vs_low = 0;
  logic prev_hs = 1;
  typedef struct {bit is_addr; int v; int h; logic [14:0] a; logic [11:0] c;} vec_t;
  vec_t tbl [0:15];
  int ntbl = 0;

  z88_vga dut (.clk(clk), .rst(rst), .pix_ena(pix_ena), .vram_data(vram_data),
    .vram_addr(vram_addr), .new_fr_tgl(new_fr_tgl), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_de(vga_de), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b));

  always #10 clk = ~clk;
  always @(posedge clk) if (pix_ena) vram_data <= mem[vram_addr];

  function automatic logic [14:0] addr_of(int h, int v);
    int col, row;
    col = h / 2;
    row = ((v - 112) / 4 + 16) % 64;
    return {col[8:0], row[5:0]};
  endfunction

  function automatic logic [11:0] pix_rgb(int h, int v);
    logic [2:0] d;
    logic on;
    logic [11:0] c;
    if (h >= 640 || v < 112 || v > 367) return 12'h000;
    d  = mem[addr_of(h, v)];
    on = (h % 2 == 0) ? d[1] : d[0];
    c  = !on ? 12'hAC8 : (d[2] ? 12'h666 : 12'h222);
`ifdef VGA_SCANLINE_EN
    if (v % 2 == 1) c = {4'(c[11:8] / 2), 4'(c[7:4] / 2), 4'(c[3:0] / 2)};
`endif
    return c;
  endfunction

  function automatic void add(bit is_addr, int v, int h, logic [14:0] a, logic [11:0] c);
    tbl[ntbl] = '{is_addr, v, h, a, c};
    ntbl++;
  endfunction

  task automatic check();
    int idx, h, v, ch, cv, toggles;
    logic ehs, evs, ede, etgl;
    logic [11:0] ec, got;
    got = {vga_r, vga_g, vga_b};
    ch = n % 800;
    cv = (n / 800) % 525;
    toggles = n / 420000 + ((n % 420000) > 384000 ? 1 : 0);
    etgl = toggles[0];
    if (n < 2) begin
      ehs = 1; evs = 1; ede = 0; ec = 0; h = -1; v = -1;
    end else begin
      idx = n - 2;
      h = idx % 800;
      v = (idx / 800) % 525;
      ehs = !(h >= 656 && h <= 751);
      evs = !(v == 490 || v == 491);
      ede = h < 640 && v < 480;
      ec  = pix_rgb(h, v);
    end
    nvec++;
    if ({new_fr_tgl, vga_hs, vga_vs, vga_de, got} !== {etgl, ehs, evs, ede, ec}) begin
      nerr++;
      $display("FAIL video n=%0d got tgl=%b hs=%b vs=%b de=%b rgb=%h expected tgl=%b hs=%b vs=%b de=%b rgb=%h",
               n, new_fr_tgl, vga_hs, vga_vs, vga_de, got, etgl, ehs, evs, ede, ec);
    end
    if (ch < 640 && cv >= 112 && cv <= 367) begin
      nvec++;
      if (vram_addr !== addr_of(ch, cv)) begin
        nerr++;
        $display("FAIL addr h=%0d v=%0d got %h expected %h", ch, cv, vram_addr, addr_of(ch, cv));
      end
    end
    for (int i = 0; i < ntbl; i++) begin
      if (tbl[i].is_addr && tbl[i].h == ch && tbl[i].v == cv) begin
        nvec++;
        if (vram_addr !== tbl[i].a) begin
          nerr++;
          $display("FAIL tbl_addr[%0d] got %h expected %h", i, vram_addr, tbl[i].a);
        end
      end
      if (!tbl[i].is_addr && tbl[i].h == h && tbl[i].v == v) begin
        nvec++;
        if (got !== tbl[i].c) begin
          nerr++;
          $display("FAIL tbl_rgb[%0d] got %h expected %h", i, got, tbl[i].c);
        end
      end
    end
    if (stat_on && n >= 2 && n <= 420001) begin
      de_cnt += vga_de ? 1 : 0;
      vs_low += vga_vs ? 0 : 1;
      hs_fall += (prev_hs && !vga_hs) ? 1 : 0;
    end
    prev_hs = vga_hs;
  endtask

  task automatic step(input bit pe, input bit r);
    @(negedge clk);
    pix_ena = pe;
    rst = r;
    @(posedge clk);
    if (r) n = 0;
    else if (pe) n++;
    #1 check();
  endtask

  task automatic stat(string name, int got, int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 3'($urandom);
    for (int c = 0; c < 512; c++) begin
      mem[{9'(c), 6'd16}] = 3'b110;
      mem[{9'(c), 6'd17}] = 3'b000;
    end
    add(0, 112, 0, 0, 12'h666);
    add(0, 112, 1, 0, 12'hAC8);
    add(0, 112, 638, 0, 12'h666);
    add(0, 112, 639, 0, 12'hAC8);
    add(0, 112, 640, 0, 12'h000);
    add(0, 111, 5, 0, 12'h000);
    add(0, 116, 4, 0, 12'hAC8);
`ifdef VGA_SCANLINE_EN
    add(0, 113, 0, 0, 12'h333);
    add(0, 117, 4, 0, 12'h564);
`else
    add(0, 113, 0, 0, 12'h666);
    add(0, 117, 4, 0, 12'hAC8);
`endif
    add(1, 112, 6, {9'd3, 6'd16}, 0);
    add(1, 367, 0, {9'd0, 6'd15}, 0);
    add(1, 367, 639, {9'd319, 6'd15}, 0);
    add(1, 116, 0, {9'd0, 6'd17}, 0);
    add(1, 115, 2, {9'd1, 6'd16}, 0);
    step(0, 1);
    step(1, 1);
    for (int i = 0; i < 4000; i++) step(i % 2 == 0, 0);
    step(1, 1);
    step(0, 0);
    stat_on = 1;
    for (int i = 0; i < 421600; i++) step(1, 0);
    stat("de_pixels", de_cnt, 640 * 480);
    stat("hs_pulses", hs_fall, 525);
    stat("vs_low_pixels", vs_low, 2 * 800);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
